// File: rtl/framemask_pkg.sv
// Shared constants for the 112x112 frame mask (writer and scanner sides).
package framemask_pkg;

   localparam int RESOLUTION     = 112;
   localparam int WORDS_PER_ROW  = 4;
   localparam int ADDR_W         = 9;
   localparam int NUM_WORDS      = RESOLUTION * WORDS_PER_ROW;
   // Valid pixel bits in the last word of each row.
   localparam int LAST_WORD_BITS = RESOLUTION - 32 * (WORDS_PER_ROW - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_EMIT  = 3'd3,
      ST_DONE  = 3'd4
   } scan_state_t;

   // Low-order mask keeping nbits bits of a 32-bit mask word.
   function automatic logic [31:0] low_bits_mask(input int nbits);
      logic [63:0] m;
      m = (64'd1 << nbits) - 64'd1;
      return m[31:0];
   endfunction

endpackage

// File: rtl/bit_find32.sv
// Combinational lowest-set-bit encoder for one 32-bit mask word.
module bit_find32 (
   input  logic [31:0] word,
   output logic [4:0]  idx,
   output logic        any
);

   // Scan from the top so the lowest set bit is the last one to win.
   always_comb begin
      idx = '0;
      for (int i = 31; i >= 0; i--) begin
         if (word[i]) idx = 5'(i);
      end
      any = |word;
   end

endmodule

// File: rtl/mask_scanner.sv
// Walks the frame mask RAM row-major and hands out each set pixel over
// a valid/ready handshake; pulses frame_done after the final word.
module mask_scanner #(
   parameter int RESOLUTION    = framemask_pkg::RESOLUTION,
   parameter int WORDS_PER_ROW = framemask_pkg::WORDS_PER_ROW,
   parameter int ADDR_W        = framemask_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [31:0]       ram_rdata,
   output logic              pix_valid,
   output logic [6:0]        pix_row,
   output logic [6:0]        pix_col,
   input  logic              pix_ready,
   output logic              busy,
   output logic              frame_done
);

   import framemask_pkg::*;

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RESOLUTION * WORDS_PER_ROW - 1);
   localparam logic [1:0]        LAST_WC   = 2'(WORDS_PER_ROW - 1);
   localparam logic [31:0]       LAST_MASK =
      low_bits_mask(RESOLUTION - 32 * (WORDS_PER_ROW - 1));

   scan_state_t state;
   logic [6:0]  row;
   logic [1:0]  wcol;
   logic [31:0] word;
   logic [4:0]  bit_idx;
   logic        word_any;

   bit_find32 u_find (
      .word (word),
      .idx  (bit_idx),
      .any  (word_any)
   );

   // Outputs are pure decodes of registered state; pix_ready only steers
   // the next state, so there is no ready-to-valid combinational path.
   assign ram_addr   = ADDR_W'({row, wcol});
   assign ram_rd_en  = (state == ST_FETCH);
   assign pix_valid  = (state == ST_EMIT) && word_any;
   assign pix_row    = row;
   assign pix_col    = {wcol, bit_idx};
   assign busy       = (state != ST_IDLE);
   assign frame_done = (state == ST_DONE);

   // Scan FSM with row/wordcol counters and the working word register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         row   <= '0;
         wcol  <= '0;
         word  <= '0;
      end else if (abort && state != ST_IDLE) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !abort) begin
                  row   <= '0;
                  wcol  <= '0;
                  word  <= '0;
                  state <= ST_FETCH;
               end
            end
            ST_FETCH: state <= ST_LATCH;
            ST_LATCH: begin
               // Columns past the frame edge in the last word are padding.
               word  <= (wcol == LAST_WC) ? (ram_rdata & LAST_MASK) : ram_rdata;
               state <= ST_EMIT;
            end
            ST_EMIT: begin
               if (word_any) begin
                  if (pix_ready) word <= word & ~(32'd1 << bit_idx);
               end else if (ram_addr == LAST_ADDR) begin
                  state <= ST_DONE;
               end else begin
                  if (wcol == LAST_WC) begin
                     wcol <= '0;
                     row  <= row + 7'd1;
                  end else begin
                     wcol <= wcol + 2'd1;
                  end
                  state <= ST_FETCH;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mask_scanner.sv
// Scoreboard bench for mask_scanner: a RAM model feeds the DUT, expected
// pixels are queued as mask words are written and popped on handshakes.
module tb_mask_scanner;

   typedef struct packed {
      logic [6:0] row;
      logic [6:0] col;
   } pix_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        ram_rd_en;
   logic [8:0]  ram_addr;
   logic [31:0] ram_rdata;
   logic        pix_valid;
   logic [6:0]  pix_row;
   logic [6:0]  pix_col;
   logic        pix_ready;
   logic        busy;
   logic        frame_done;

   logic [31:0] mem [448];
   pix_t        exp_q [$];
   int          hs_cyc [$];
   int          total = 0;
   int          bad = 0;

   int r_done_cyc, r_ndone, r_hs, r_rdbad, r_addr1, r_last_busy;

   always #5 clk = ~clk;

   // Two-port RAM read side: data one cycle after the strobe.
   always @(posedge clk) if (ram_rd_en) ram_rdata <= mem[ram_addr];

   mask_scanner dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .abort      (abort),
      .ram_rd_en  (ram_rd_en),
      .ram_addr   (ram_addr),
      .ram_rdata  (ram_rdata),
      .pix_valid  (pix_valid),
      .pix_row    (pix_row),
      .pix_col    (pix_col),
      .pix_ready  (pix_ready),
      .busy       (busy),
      .frame_done (frame_done)
   );

   task automatic clear_mem();
      for (int i = 0; i < 448; i++) mem[i] = 32'd0;
      exp_q.delete();
      hs_cyc.delete();
   endtask

   // Words must be written in ascending address order so the queue is row-major.
   task automatic set_word(input int a, input logic [31:0] w);
      pix_t p;
      mem[a] = w;
      for (int b = 0; b < 32; b++) begin
         p.row = 7'(a / 4);
         p.col = 7'(32 * (a % 4) + b);
         if (w[b] && (32 * (a % 4) + b) < 112) exp_q.push_back(p);
      end
   endtask

   // Leaves the bench at the negedge of cycle 1 (start sampled end of cycle 0).
   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Runs one scan to completion; stall_n holds ready low on the first pixel.
   task automatic scan(input int stall_n, input bit chk_rd);
      int   cyc;
      int   stall;
      bit   fin;
      pix_t e;
      cyc = 1; stall = stall_n; fin = 0;
      r_done_cyc = -1; r_ndone = 0; r_hs = 0; r_rdbad = 0; r_addr1 = -1; r_last_busy = -1;
      while (!fin) begin
         if (busy) r_last_busy = cyc;
         if (chk_rd && (ram_rd_en !== ((cyc % 3 == 1) && (cyc <= 1342)))) r_rdbad++;
         if (ram_rd_en && ram_addr == 9'd1 && r_addr1 < 0) r_addr1 = cyc;
         if (frame_done) begin
            if (r_done_cyc < 0) r_done_cyc = cyc;
            r_ndone++;
         end
         pix_ready = 1'b1;
         if (pix_valid) begin
            total++;
            if (frame_done) begin
               bad++;
               $display("FAIL valid_with_done cyc=%0d got=1 want=0", cyc);
            end
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL extra_pixel cyc=%0d got=(%0d,%0d) want=none", cyc, pix_row, pix_col);
               r_hs++;
            end else begin
               e = exp_q[0];
               if ({pix_row, pix_col} !== e) begin
                  bad++;
                  $display("FAIL pixel cyc=%0d got=(%0d,%0d) want=(%0d,%0d)",
                           cyc, pix_row, pix_col, e.row, e.col);
               end
               if (stall > 0) begin
                  pix_ready = 1'b0;
                  stall--;
               end else begin
                  void'(exp_q.pop_front());
                  r_hs++;
                  hs_cyc.push_back(cyc);
               end
            end
         end
         if (r_done_cyc >= 0 && !busy) fin = 1;
         else if (cyc >= 3000) begin
            total++; bad++;
            $display("FAIL scan_timeout cyc=%0d got=busy want=idle", cyc);
            fin = 1;
         end else begin
            @(negedge clk);
            cyc++;
         end
      end
      pix_ready = 1'b1;
   endtask

   task automatic chk_int(input string name, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done} !== 27'd0) begin
         bad++;
         $display("FAIL reset_outputs got=%h want=0",
                  {ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done} !== 27'd0) begin
         bad++;
         $display("FAIL idle_outputs got=%h want=0",
                  {ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done});
      end
   endtask

   task automatic test_empty_frame();
      clear_mem();
      do_start();
      scan(0, 1'b1);
      chk_int("empty_handshakes", r_hs, 0);
      chk_int("empty_done_cycle", r_done_cyc, 1345);
      chk_int("empty_done_count", r_ndone, 1);
      chk_int("empty_rd_en_pattern_errors", r_rdbad, 0);
      chk_int("empty_last_busy", r_last_busy, 1345);
   endtask

   task automatic test_single_pixel();
      clear_mem();
      set_word(21, 32'h0000_0100);
      do_start();
      scan(0, 1'b0);
      chk_int("single_handshakes", r_hs, 1);
      chk_int("single_done_cycle", r_done_cyc, 1346);
      chk_int("single_left_in_queue", exp_q.size(), 0);
   endtask

   task automatic test_back_to_back();
      clear_mem();
      set_word(0, 32'h8000_0001);
      do_start();
      scan(0, 1'b0);
      chk_int("b2b_handshakes", r_hs, 2);
      chk_int("b2b_first_cycle", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, 3);
      chk_int("b2b_second_cycle", (hs_cyc.size() > 1) ? hs_cyc[1] : -1, 4);
      chk_int("b2b_fetch_word1", r_addr1, 6);
      chk_int("b2b_done_cycle", r_done_cyc, 1347);
   endtask

   task automatic test_backpressure();
      clear_mem();
      set_word(0, 32'h8000_0001);
      do_start();
      scan(5, 1'b0);
      chk_int("bp_handshakes", r_hs, 2);
      chk_int("bp_first_cycle", (hs_cyc.size() > 0) ? hs_cyc[0] : -1, 8);
      chk_int("bp_second_cycle", (hs_cyc.size() > 1) ? hs_cyc[1] : -1, 9);
      chk_int("bp_fetch_word1", r_addr1, 11);
      chk_int("bp_done_cycle", r_done_cyc, 1352);
   endtask

   task automatic test_out_of_range();
      clear_mem();
      set_word(3, 32'hFFFF_8000);
      do_start();
      scan(0, 1'b0);
      chk_int("oor_handshakes", r_hs, 1);
      chk_int("oor_left_in_queue", exp_q.size(), 0);
      chk_int("oor_done_cycle", r_done_cyc, 1346);
   endtask

   task automatic test_abort();
      bit found;
      int ndone;
      int nbusy;
      clear_mem();
      set_word(10, 32'h0000_0003);
      pix_ready = 1'b0;
      do_start();
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (pix_valid) found = 1;
         else @(negedge clk);
      end
      chk_int("abort_reached_emit", int'(found), 1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk_int("abort_busy", int'(busy), 0);
      chk_int("abort_pix_valid", int'(pix_valid), 0);
      ndone = 0;
      nbusy = 0;
      for (int c = 0; c < 20; c++) begin
         if (frame_done) ndone++;
         if (busy) nbusy++;
         @(negedge clk);
      end
      chk_int("abort_no_frame_done", ndone, 0);
      chk_int("abort_stays_idle", nbusy, 0);
      // abort beats start while idle
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk_int("abort_wins_over_start", int'(busy), 0);
      pix_ready = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      clear_mem();
      set_word(0, 32'h0000_0001);
      pix_ready = 1'b0;
      do_start();
      repeat (2) @(negedge clk);
      chk_int("areset_pre_valid", int'(pix_valid), 1);
      #2 reset = 1'b0;
      #1;
      total++;
      if ({ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done} !== 27'd0) begin
         bad++;
         $display("FAIL async_reset_outputs got=%h want=0",
                  {ram_rd_en, ram_addr, pix_valid, pix_row, pix_col, busy, frame_done});
      end
      @(negedge clk);
      reset = 1'b1;
      pix_ready = 1'b1;
      exp_q.delete();
   endtask

   initial begin
      test_reset();
      test_empty_frame();
      test_single_pixel();
      test_back_to_back();
      test_backpressure();
      test_out_of_range();
      test_abort();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
